// File: rtl/uart_rx_oversampled_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled_if
// Description : Serial-line and received-word bundle for the oversampled UART
//               receiver. The slave side is the receiver itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 framing_error;
    logic                 busy;

    modport master (
        output sample_tick,
        output rx,
        input  rx_data,
        input  rx_valid,
        input  framing_error,
        input  busy
    );

    modport slave (
        input  sample_tick,
        input  rx,
        output rx_data,
        output rx_valid,
        output framing_error,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : Oversampled UART receiver, one start / DATA_BITS data (LSB
//               first) / one stop bit, with framing-error and break handling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
    parameter int DATA_BITS   = 8,
    parameter int SAMPLE_RATE = 16
) (
    input wire logic              clk,
    input wire logic              rst,
    uart_rx_oversampled_if.slave  bus
);
    localparam int c_cnt_w = $clog2(SAMPLE_RATE);
    localparam int c_bit_w = $clog2(DATA_BITS + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(SAMPLE_RATE / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_last = c_cnt_w'(SAMPLE_RATE - 1);
    localparam logic [c_bit_w-1:0] c_bit_one   = c_bit_w'(1);
    localparam logic [c_bit_w-1:0] c_last_bit  = c_bit_w'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [c_cnt_w-1:0]   r_sample_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_framing_error;
    logic                 w_rx;

    // Presetting to 1 keeps the idle-high line from looking like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx = r_rx_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_sample_cnt    <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_rx_valid      <= 1'b0;
            r_framing_error <= 1'b0;
            if (bus.sample_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_rx) begin
                            r_state      <= S_START;
                            r_sample_cnt <= '0;
                        end
                    end
                    S_START: begin
                        // Re-check the line at the centre of the start bit to reject glitches
                        if (r_sample_cnt == c_half_last) begin
                            r_sample_cnt <= '0;
                            r_bit_cnt    <= '0;
                            r_state      <= w_rx ? S_IDLE : S_DATA;
                        end else begin
                            r_sample_cnt <= r_sample_cnt + c_cnt_one;
                        end
                    end
                    S_DATA: begin
                        if (r_sample_cnt == c_full_last) begin
                            r_sample_cnt <= '0;
                            r_shift      <= {w_rx, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == c_last_bit) begin
                                r_bit_cnt <= '0;
                                r_state   <= S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_bit_one;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + c_cnt_one;
                        end
                    end
                    S_STOP: begin
                        if (r_sample_cnt == c_full_last) begin
                            r_sample_cnt <= '0;
                            if (w_rx) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                                r_state    <= S_IDLE;
                            end else begin
                                r_framing_error <= 1'b1;
                                r_state         <= S_BREAK;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + c_cnt_one;
                        end
                    end
                    S_BREAK: begin
                        // A held-low line must go high before another frame is accepted
                        if (w_rx) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = r_rx_valid;
    assign bus.framing_error = r_framing_error;
    assign bus.busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversampled
// Description : Self-checking bench for uart_rx_oversampled (16x, 8 data bits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;
    localparam int DATA_BITS   = 8;
    localparam int SAMPLE_RATE = 16;
    localparam int TICK_DIV    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_oversampled_if #(.DATA_BITS(DATA_BITS)) bus_if();

    uart_rx_oversampled #(
        .DATA_BITS   (DATA_BITS),
        .SAMPLE_RATE (SAMPLE_RATE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Baud tick source: one pulse every TICK_DIV clocks, gateable for stall tests
    bit tick_en    = 1'b1;
    int tick_phase = 0;
    int tick_count = 0;
    always @(posedge clk) begin
        #1;
        bus_if.sample_tick = tick_en && (tick_phase == 0);
        if (bus_if.sample_tick) tick_count++;
        tick_phase = (tick_phase + 1) % TICK_DIV;
    end

    // Output monitor, sampled after outputs settle
    int cyc = 0, valid_cnt = 0, fe_cnt = 0, busy_cyc = 0;
    int last_valid_cyc = 0, prev_valid_cyc = 0;
    bit both_seen = 1'b0;
    logic [DATA_BITS-1:0] data_q[$];
    always @(posedge clk) begin
        #2;
        cyc++;
        if (bus_if.rx_valid) begin
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            valid_cnt++;
            data_q.push_back(bus_if.rx_data);
        end
        if (bus_if.framing_error) fe_cnt++;
        if (bus_if.rx_valid && bus_if.framing_error) both_seen = 1'b1;
        if (bus_if.busy) busy_cyc++;
    end

    // Reference model: last correctly framed word
    logic [DATA_BITS-1:0] exp_data;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic wait_ticks(input int n);
        int target;
        target = tick_count + n;
        while (tick_count < target) @(negedge clk);
    endtask

    task automatic send_bit(input logic v, input int n);
        bus_if.rx = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_bit);
        send_bit(1'b0, SAMPLE_RATE);
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i], SAMPLE_RATE);
        send_bit(stop_bit, SAMPLE_RATE);
    endtask

    task automatic test_reset();
        bus_if.rx = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (bus_if.rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h required 00", bus_if.rx_data); else n_pass++;
        n_checks++; if (bus_if.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b required 0", bus_if.rx_valid); else n_pass++;
        n_checks++; if (bus_if.framing_error !== 1'b0) $display("FAIL reset_framing_error: got %b required 0", bus_if.framing_error); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus_if.busy); else n_pass++;
        rst = 1'b0;
        exp_data = '0;
        wait_ticks(8);
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL idle_busy: got %b required 0", bus_if.busy); else n_pass++;
    endtask

    task automatic test_single_frame();
        int v0, f0, b0;
        v0 = valid_cnt; f0 = fe_cnt; b0 = busy_cyc;
        send_frame(8'hA5, 1'b1);
        exp_data = 8'hA5;
        wait_ticks(4);
        n_checks++; if (valid_cnt - v0 != 1) $display("FAIL a5_valid_count: got %0d required 1", valid_cnt - v0); else n_pass++;
        n_checks++; if (bus_if.rx_data !== exp_data) $display("FAIL a5_rx_data: got %h required %h", bus_if.rx_data, exp_data); else n_pass++;
        n_checks++; if (fe_cnt != f0) $display("FAIL a5_framing_error: got %0d required 0", fe_cnt - f0); else n_pass++;
        // 9.5 bit times of 64 clocks
        n_checks++; if ((busy_cyc - b0) < 600 || (busy_cyc - b0) > 616) $display("FAIL a5_busy_cycles: got %0d required 608+-8", busy_cyc - b0); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL a5_busy_after: got %b required 0", bus_if.busy); else n_pass++;
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = valid_cnt; f0 = fe_cnt;
        bus_if.rx = 1'b0;
        wait_ticks(4);
        n_checks++; if (bus_if.busy !== 1'b1) $display("FAIL glitch_busy_during: got %b required 1", bus_if.busy); else n_pass++;
        bus_if.rx = 1'b1;
        wait_ticks(12);
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL glitch_busy_after: got %b required 0", bus_if.busy); else n_pass++;
        n_checks++; if (valid_cnt != v0) $display("FAIL glitch_valid: got %0d required 0", valid_cnt - v0); else n_pass++;
        n_checks++; if (fe_cnt != f0) $display("FAIL glitch_framing_error: got %0d required 0", fe_cnt - f0); else n_pass++;
        n_checks++; if (bus_if.rx_data !== exp_data) $display("FAIL glitch_rx_data: got %h required %h", bus_if.rx_data, exp_data); else n_pass++;
    endtask

    task automatic test_framing_error();
        int v0, f0;
        v0 = valid_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        send_bit(1'b0, 3 * SAMPLE_RATE);
        n_checks++; if (fe_cnt - f0 != 1) $display("FAIL fe_count: got %0d required 1", fe_cnt - f0); else n_pass++;
        n_checks++; if (valid_cnt != v0) $display("FAIL fe_valid: got %0d required 0", valid_cnt - v0); else n_pass++;
        n_checks++; if (bus_if.rx_data !== exp_data) $display("FAIL fe_rx_data: got %h required %h", bus_if.rx_data, exp_data); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b1) $display("FAIL fe_busy_in_break: got %b required 1", bus_if.busy); else n_pass++;
        send_bit(1'b1, 4);
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL fe_busy_release: got %b required 0", bus_if.busy); else n_pass++;
        n_checks++; if (valid_cnt != v0 || fe_cnt - f0 != 1) $display("FAIL fe_no_more_frames: got valid %0d fe %0d required 0 and 1", valid_cnt - v0, fe_cnt - f0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int v0, gap;
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        exp_data = 8'hFF;
        wait_ticks(2);
        gap = last_valid_cyc - prev_valid_cyc;
        n_checks++; if (valid_cnt - v0 != 2) $display("FAIL b2b_valid_count: got %0d required 2", valid_cnt - v0); else n_pass++;
        if (data_q.size() >= 2) begin
            n_checks++; if (data_q[data_q.size()-2] !== 8'h00) $display("FAIL b2b_first_data: got %h required 00", data_q[data_q.size()-2]); else n_pass++;
        end
        n_checks++; if (bus_if.rx_data !== exp_data) $display("FAIL b2b_second_data: got %h required %h", bus_if.rx_data, exp_data); else n_pass++;
        n_checks++; if (gap < 636 || gap > 644) $display("FAIL b2b_spacing: got %0d required 640+-4", gap); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int v0, f0;
        logic [DATA_BITS-1:0] d;
        d = 8'h5A;
        v0 = valid_cnt; f0 = fe_cnt;
        send_bit(1'b0, SAMPLE_RATE);
        for (int i = 0; i < 4; i++) send_bit(d[i], SAMPLE_RATE);
        send_bit(d[4], 6);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_data = '0;
        n_checks++; if (bus_if.rx_data !== exp_data) $display("FAIL midrst_rx_data: got %h required %h", bus_if.rx_data, exp_data); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", bus_if.busy); else n_pass++;
        bus_if.rx = 1'b1;
        rst = 1'b0;
        wait_ticks(3 * SAMPLE_RATE);
        n_checks++; if (valid_cnt != v0 || fe_cnt != f0) $display("FAIL midrst_aborted: got valid %0d fe %0d required 0 and 0", valid_cnt - v0, fe_cnt - f0); else n_pass++;
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL midrst_busy_after: got %b required 0", bus_if.busy); else n_pass++;
        send_frame(8'h81, 1'b1);
        exp_data = 8'h81;
        wait_ticks(2);
        n_checks++; if (valid_cnt - v0 != 1) $display("FAIL midrst_new_valid: got %0d required 1", valid_cnt - v0); else n_pass++;
        n_checks++; if (bus_if.rx_data !== exp_data) $display("FAIL midrst_new_data: got %h required %h", bus_if.rx_data, exp_data); else n_pass++;
    endtask

    task automatic test_tick_stall();
        int v0, f0;
        logic [DATA_BITS-1:0] d;
        d = 8'hC3;
        v0 = valid_cnt; f0 = fe_cnt;
        send_bit(1'b0, SAMPLE_RATE);
        for (int i = 0; i < DATA_BITS; i++) begin
            if (i == 3) begin
                send_bit(d[i], 4);
                tick_en = 1'b0;
                // Line activity while ticks are stopped must not be seen
                bus_if.rx = ~d[i];
                repeat (100) @(negedge clk);
                n_checks++; if (bus_if.busy !== 1'b1) $display("FAIL stall_busy: got %b required 1", bus_if.busy); else n_pass++;
                n_checks++; if (valid_cnt != v0 || fe_cnt != f0) $display("FAIL stall_outputs: got valid %0d fe %0d required 0 and 0", valid_cnt - v0, fe_cnt - f0); else n_pass++;
                bus_if.rx = d[i];
                repeat (4) @(negedge clk);
                tick_en = 1'b1;
                wait_ticks(SAMPLE_RATE - 4);
            end else begin
                send_bit(d[i], SAMPLE_RATE);
            end
        end
        send_bit(1'b1, SAMPLE_RATE);
        exp_data = d;
        n_checks++; if (valid_cnt - v0 != 1) $display("FAIL stall_valid: got %0d required 1", valid_cnt - v0); else n_pass++;
        n_checks++; if (bus_if.rx_data !== exp_data) $display("FAIL stall_rx_data: got %h required %h", bus_if.rx_data, exp_data); else n_pass++;
        n_checks++; if (fe_cnt != f0) $display("FAIL stall_framing_error: got %0d required 0", fe_cnt - f0); else n_pass++;
    endtask

    task automatic test_random();
        int v0, f0;
        logic [DATA_BITS-1:0] d;
        logic stop_bit;
        for (int k = 0; k < 12; k++) begin
            d = DATA_BITS'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            v0 = valid_cnt; f0 = fe_cnt;
            send_frame(d, stop_bit);
            if (stop_bit) begin
                exp_data = d;
                n_checks++; if (valid_cnt - v0 != 1 || bus_if.rx_data !== exp_data) $display("FAIL rand_good_%0d: got valid %0d data %h required 1 and %h", k, valid_cnt - v0, bus_if.rx_data, exp_data); else n_pass++;
                n_checks++; if (fe_cnt != f0) $display("FAIL rand_good_fe_%0d: got %0d required 0", k, fe_cnt - f0); else n_pass++;
                if ($urandom_range(0, 1) != 0) send_bit(1'b1, $urandom_range(1, 3));
            end else begin
                n_checks++; if (fe_cnt - f0 != 1 || valid_cnt != v0) $display("FAIL rand_bad_%0d: got fe %0d valid %0d required 1 and 0", k, fe_cnt - f0, valid_cnt - v0); else n_pass++;
                n_checks++; if (bus_if.rx_data !== exp_data) $display("FAIL rand_bad_data_%0d: got %h required %h", k, bus_if.rx_data, exp_data); else n_pass++;
                send_bit(1'b1, $urandom_range(2, 6));
            end
        end
        wait_ticks(4);
        n_checks++; if (bus_if.busy !== 1'b0) $display("FAIL rand_idle_busy: got %b required 0", bus_if.busy); else n_pass++;
    endtask

    initial begin
        bus_if.rx = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_midframe();
        test_tick_stall();
        test_random();
        n_checks++; if (both_seen !== 1'b0) $display("FAIL valid_fe_exclusive: got %b required 0", both_seen); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
